// File: rtl/serial_mod_n_pkg.sv
// Shared types for the serial remainder engine: FSM state and bit ordering.
package serial_mod_pkg;

  // Frame tracker: IDLE waits for a start beat, RUN accumulates bits.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit ordering of the current frame, latched from lsb_first on the start beat.
  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } mode_t;

  // Debug view of the engine's control state.
  typedef struct packed {
    state_t state;
    mode_t  mode;
  } dbg_t;

endpackage : serial_mod_pkg

// File: rtl/serial_mod_n_if.sv
// Bit-stream and result bundle of serial_mod_n.
//
// Handshake: in_valid qualifies in_bit/in_start/in_last/lsb_first on the rising
// clock edge. There is no ready signal; the engine accepts every qualified beat
// in the cycle it is presented. Beats with in_valid low are bubbles and change
// nothing. Result outputs are registered: rem_valid, abort and orphan are
// one-cycle pulses in the cycle after the beat that caused them.
interface serial_mod_n_if
  import serial_mod_pkg::*;
#(
  parameter int REM_W = 2,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             in_start;
  logic             in_last;
  logic             lsb_first;
  logic [REM_W-1:0] run_rem;
  logic [REM_W-1:0] rem_o;
  logic             rem_valid;
  logic             div_o;
  logic [CNT_W-1:0] bit_cnt;
  logic             abort;
  logic             orphan;
  dbg_t             dbg;

  // Stream source side.
  modport master (
    output in_valid, in_bit, in_start, in_last, lsb_first,
    input  run_rem, rem_o, rem_valid, div_o, bit_cnt, abort, orphan, dbg
  );

  // Remainder engine side.
  modport slave (
    input  in_valid, in_bit, in_start, in_last, lsb_first,
    output run_rem, rem_o, rem_valid, div_o, bit_cnt, abort, orphan, dbg
  );
endinterface : serial_mod_n_if

// File: rtl/mod_n_add.sv
// Modular adder: (a + b) mod DIVISOR for operands already reduced below DIVISOR.
// The sum is below 2*DIVISOR, so one conditional subtract fully reduces it.
module mod_n_add #(
  parameter int DIVISOR = 3,
  parameter int REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] i_a,
  input  logic [REM_W-1:0] i_b,
  output logic [REM_W-1:0] o_sum
);

  localparam logic [REM_W:0] N_EXT = (REM_W + 1)'(DIVISOR);

  logic [REM_W:0] w_sum;
  logic [REM_W:0] w_red;

  // Widen by one bit so the carry is kept, then subtract N once if needed.
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    w_red = w_sum - N_EXT;
    o_sum = (w_sum >= N_EXT) ? w_red[REM_W-1:0] : w_sum[REM_W-1:0];
  end

endmodule : mod_n_add

// File: rtl/serial_mod_n.sv
// Serial remainder engine: tracks the value of a framed bit stream mod DIVISOR,
// in MSB-first or LSB-first order, and reports remainder plus divisibility at
// the end of every frame.
//
// MSB-first: r' = (2r + bit) mod N.
// LSB-first: r' = (r + bit * w) mod N, w' = 2w mod N, with w = 2^i mod N.
module serial_mod_n
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  serial_mod_n_if.slave bus
);

  localparam int REM_W = $clog2(DIVISOR);
  localparam logic [REM_W:0]   N_EXT   = (REM_W + 1)'(DIVISOR);
  // Weight of the second bit of an LSB-first frame: 2 mod N.
  localparam logic [REM_W-1:0] W_START = (DIVISOR == 2) ? '0 : REM_W'(2);

  if ((DIVISOR < 2) || (DIVISOR > 255)) begin : g_bad_divisor
    $error("serial_mod_n: DIVISOR must be within 2..255");
  end

  state_t           r_state;
  mode_t            r_mode;
  logic [REM_W-1:0] r_run_rem;
  logic [REM_W-1:0] r_weight;
  logic [REM_W-1:0] r_rem_o;
  logic             r_rem_valid;
  logic             r_div_o;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_abort;
  logic             r_orphan;

  logic [REM_W-1:0] w_add_b;
  logic [REM_W-1:0] w_step_sum;
  logic [REM_W-1:0] w_weight_dbl;
  logic [REM_W:0]   w_msb_t;
  logic [REM_W:0]   w_msb_red;
  logic [REM_W-1:0] w_msb_rem;
  logic [REM_W-1:0] w_next_rem;

  // Data adder operand: run_rem again for MSB doubling, the bit's weight for LSB.
  always_comb begin
    w_add_b = r_run_rem;
    if (r_mode == LSB_FIRST) begin
      w_add_b = bus.in_bit ? r_weight : '0;
    end
  end

  mod_n_add #(
    .DIVISOR (DIVISOR),
    .REM_W   (REM_W)
  ) u_step_add (
    .i_a   (r_run_rem),
    .i_b   (w_add_b),
    .o_sum (w_step_sum)
  );

  mod_n_add #(
    .DIVISOR (DIVISOR),
    .REM_W   (REM_W)
  ) u_weight_dbl (
    .i_a   (r_weight),
    .i_b   (r_weight),
    .o_sum (w_weight_dbl)
  );

  // Next running remainder: MSB adds the incoming bit as carry-in to 2r mod N.
  always_comb begin
    w_msb_t   = {1'b0, w_step_sum} + {{REM_W{1'b0}}, bus.in_bit};
    w_msb_red = w_msb_t - N_EXT;
    w_msb_rem = (w_msb_t >= N_EXT) ? w_msb_red[REM_W-1:0] : w_msb_t[REM_W-1:0];
    w_next_rem = (r_mode == MSB_FIRST) ? w_msb_rem : w_step_sum;
  end

  // Frame FSM with registered datapath and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= MSB_FIRST;
      r_run_rem   <= '0;
      r_weight    <= REM_W'(1);
      r_rem_o     <= '0;
      r_rem_valid <= 1'b0;
      r_div_o     <= 1'b1;
      r_bit_cnt   <= '0;
      r_abort     <= 1'b0;
      r_orphan    <= 1'b0;
    end else begin
      r_rem_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_orphan    <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_start) begin
          // A start always opens a fresh frame; an open one is discarded.
          r_abort   <= (r_state == RUN);
          r_mode    <= bus.lsb_first ? LSB_FIRST : MSB_FIRST;
          r_run_rem <= REM_W'(bus.in_bit);
          r_weight  <= W_START;
          r_bit_cnt <= CNT_W'(1);
          if (bus.in_last) begin
            r_state     <= IDLE;
            r_rem_valid <= 1'b1;
            r_rem_o     <= REM_W'(bus.in_bit);
            r_div_o     <= ~bus.in_bit;
          end else begin
            r_state <= RUN;
          end
        end else if (r_state == RUN) begin
          r_run_rem <= w_next_rem;
          if (r_mode == LSB_FIRST) begin
            r_weight <= w_weight_dbl;
          end
          if (r_bit_cnt != '1) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (bus.in_last) begin
            r_state     <= IDLE;
            r_rem_valid <= 1'b1;
            r_rem_o     <= w_next_rem;
            r_div_o     <= (w_next_rem == '0);
          end
        end else begin
          // Data beat with no open frame: dropped and flagged.
          r_orphan <= 1'b1;
        end
      end
    end
  end

  assign bus.run_rem   = r_run_rem;
  assign bus.rem_o     = r_rem_o;
  assign bus.rem_valid = r_rem_valid;
  assign bus.div_o     = r_div_o;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.abort     = r_abort;
  assign bus.orphan    = r_orphan;
  assign bus.dbg       = '{state: r_state, mode: r_mode};

endmodule : serial_mod_n

// File: tb/tb_serial_mod_n.sv
// Bench for serial_mod_n: five engines (N = 3, 5, 7, 2, 255) share one stimulus
// stream; a frame-level model turns each frame's bits into an integer and takes
// it mod N to produce expected running and final remainders.
module tb_serial_mod_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_bit   = 1'b0;
  logic s_start = 1'b0;
  logic s_last  = 1'b0;
  logic s_lsb   = 1'b0;

  int checks = 0;
  int errors = 0;
  int ns[5] = '{3, 5, 7, 2, 255};

  // Clock and reset
  always #5 clk = ~clk;

  serial_mod_n_if #(.REM_W(2)) if3 ();
  serial_mod_n_if #(.REM_W(3)) if5 ();
  serial_mod_n_if #(.REM_W(3)) if7 ();
  serial_mod_n_if #(.REM_W(1)) if2 ();
  serial_mod_n_if #(.REM_W(8)) if255 ();

  assign {if3.in_valid, if3.in_bit, if3.in_start, if3.in_last, if3.lsb_first} = {s_valid, s_bit, s_start, s_last, s_lsb};
  assign {if5.in_valid, if5.in_bit, if5.in_start, if5.in_last, if5.lsb_first} = {s_valid, s_bit, s_start, s_last, s_lsb};
  assign {if7.in_valid, if7.in_bit, if7.in_start, if7.in_last, if7.lsb_first} = {s_valid, s_bit, s_start, s_last, s_lsb};
  assign {if2.in_valid, if2.in_bit, if2.in_start, if2.in_last, if2.lsb_first} = {s_valid, s_bit, s_start, s_last, s_lsb};
  assign {if255.in_valid, if255.in_bit, if255.in_start, if255.in_last, if255.lsb_first} = {s_valid, s_bit, s_start, s_last, s_lsb};

  serial_mod_n #(.DIVISOR(3))   u_d3   (.clk(clk), .rst(rst), .bus(if3.slave));
  serial_mod_n #(.DIVISOR(5))   u_d5   (.clk(clk), .rst(rst), .bus(if5.slave));
  serial_mod_n #(.DIVISOR(7))   u_d7   (.clk(clk), .rst(rst), .bus(if7.slave));
  serial_mod_n #(.DIVISOR(2))   u_d2   (.clk(clk), .rst(rst), .bus(if2.slave));
  serial_mod_n #(.DIVISOR(255)) u_d255 (.clk(clk), .rst(rst), .bus(if255.slave));

  logic [7:0]  act_run[5];
  logic [7:0]  act_rem[5];
  logic        act_rv[5];
  logic        act_div[5];
  logic        act_ab[5];
  logic        act_or[5];
  logic [15:0] act_cnt[5];

  assign act_run[0] = 8'(if3.run_rem);
  assign act_run[1] = 8'(if5.run_rem);
  assign act_run[2] = 8'(if7.run_rem);
  assign act_run[3] = 8'(if2.run_rem);
  assign act_run[4] = if255.run_rem;
  assign act_rem[0] = 8'(if3.rem_o);
  assign act_rem[1] = 8'(if5.rem_o);
  assign act_rem[2] = 8'(if7.rem_o);
  assign act_rem[3] = 8'(if2.rem_o);
  assign act_rem[4] = if255.rem_o;
  assign act_rv  = '{if3.rem_valid, if5.rem_valid, if7.rem_valid, if2.rem_valid, if255.rem_valid};
  assign act_div = '{if3.div_o, if5.div_o, if7.div_o, if2.div_o, if255.div_o};
  assign act_ab  = '{if3.abort, if5.abort, if7.abort, if2.abort, if255.abort};
  assign act_or  = '{if3.orphan, if5.orphan, if7.orphan, if2.orphan, if255.orphan};
  assign act_cnt = '{if3.bit_cnt, if5.bit_cnt, if7.bit_cnt, if2.bit_cnt, if255.bit_cnt};

  // Reference model: the open frame's bits, its ordering, expected outputs.
  logic       fr_q[$];
  logic       mdl_open;
  logic       mdl_lsb;
  logic [7:0] exp_run[5];
  logic [7:0] exp_rem[5];
  logic       exp_div[5];
  int         exp_cnt;
  logic       exp_rv, exp_ab, exp_or;
  logic [39:0] exp_q[$];

  // Frame value as a plain integer (frames here are at most 64 bits), mod n.
  function automatic logic [7:0] frame_mod(input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < fr_q.size(); i++) begin
      if (mdl_lsb) v[i] = fr_q[i];
      else         v = {v[62:0], fr_q[i]};
    end
    return 8'(v % 64'(n));
  endfunction

  task automatic mdl_reset();
    fr_q.delete();
    exp_q.delete();
    mdl_open = 1'b0;
    mdl_lsb  = 1'b0;
    exp_cnt  = 0;
    exp_rv = 1'b0; exp_ab = 1'b0; exp_or = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_run[k] = '0; exp_rem[k] = '0; exp_div[k] = 1'b1;
    end
  endtask

  // Driver: present one valid beat for one clock, then update the model.
  task automatic drive_beat(input logic b, input logic st, input logic la, input logic lsb);
    logic [39:0] w;
    s_valid = 1'b1; s_bit = b; s_start = st; s_last = la; s_lsb = lsb;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_start = 1'b0; s_last = 1'b0;
    exp_rv = 1'b0; exp_ab = 1'b0; exp_or = 1'b0;
    if (st) begin
      exp_ab = mdl_open;
      fr_q.delete();
      fr_q.push_back(b);
      mdl_lsb  = lsb;
      mdl_open = !la;
    end else if (mdl_open) begin
      fr_q.push_back(b);
      if (la) mdl_open = 1'b0;
    end else begin
      exp_or = 1'b1;
    end
    if (!exp_or) begin
      for (int k = 0; k < 5; k++) exp_run[k] = frame_mod(ns[k]);
      exp_cnt = (fr_q.size() > 65535) ? 65535 : fr_q.size();
      if (la) begin
        exp_rv = 1'b1;
        for (int k = 0; k < 5; k++) begin
          exp_rem[k] = exp_run[k];
          exp_div[k] = (exp_run[k] == 8'd0);
          w[8*k +: 8] = exp_run[k];
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
    exp_rv = 1'b0; exp_ab = 1'b0; exp_or = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_run[k] !== 8'd0 || act_rem[k] !== 8'd0 || act_cnt[k] !== 16'd0 ||
          act_div[k] !== 1'b1 || act_rv[k] !== 1'b0 || act_ab[k] !== 1'b0 || act_or[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset N=%0d got run=%0d rem=%0d cnt=%0d div=%0b rv=%0b ab=%0b or=%0b exp 0,0,0,1,0,0,0",
                 ns[k], act_run[k], act_rem[k], act_cnt[k], act_div[k], act_rv[k], act_ab[k], act_or[k]);
      end
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_msb_mod3();
    logic [3:0] pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      drive_beat(pat[3-i], i == 0, i == 3, 1'b0);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (act_run[k] !== exp_run[k]) begin
          errors++;
          $display("FAIL msb_run N=%0d beat %0d got %0d exp %0d", ns[k], i, act_run[k], exp_run[k]);
        end
      end
    end
    checks++;
    if (act_rv[0] !== 1'b1 || act_rem[0] !== 8'd2 || act_div[0] !== 1'b0 || act_cnt[0] !== 16'd4) begin
      errors++;
      $display("FAIL msb_mod3 got rv=%0b rem=%0d div=%0b cnt=%0d exp 1,2,0,4",
               act_rv[0], act_rem[0], act_div[0], act_cnt[0]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_rem[k] !== exp_rem[k] || act_div[k] !== exp_div[k]) begin
        errors++;
        $display("FAIL msb_rem N=%0d got %0d/%0b exp %0d/%0b", ns[k], act_rem[k], act_div[k], exp_rem[k], exp_div[k]);
      end
    end
    idle(1);
    checks++;
    if (act_rv[0] !== 1'b0 || act_rem[0] !== 8'd2) begin
      errors++;
      $display("FAIL msb_hold got rv=%0b rem=%0d exp 0,2", act_rv[0], act_rem[0]);
    end
  endtask

  task automatic test_lsb_bubbles();
    logic [3:0] pat = 4'b1101;
    logic [7:0] seq5[4] = '{8'd1, 8'd3, 8'd3, 8'd1};
    for (int i = 0; i < 4; i++) begin
      drive_beat(pat[3-i], i == 0, i == 3, (i == 0) ? 1'b1 : 1'b0);
      checks++;
      if (act_run[1] !== seq5[i]) begin
        errors++;
        $display("FAIL lsb_run5 beat %0d got %0d exp %0d", i, act_run[1], seq5[i]);
      end
      if (i == 3) begin
        checks++;
        if (act_rv[1] !== 1'b1 || act_rem[1] !== 8'd1 || act_div[1] !== 1'b0) begin
          errors++;
          $display("FAIL lsb_rem5 got rv=%0b rem=%0d div=%0b exp 1,1,0", act_rv[1], act_rem[1], act_div[1]);
        end
      end
      idle(2);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (act_run[k] !== exp_run[k] || act_rv[k] !== 1'b0) begin
          errors++;
          $display("FAIL lsb_bubble N=%0d got run=%0d rv=%0b exp %0d,0", ns[k], act_run[k], act_rv[k], exp_run[k]);
        end
      end
    end
  endtask

  task automatic test_div7_single();
    logic [4:0] pat = 5'b10101;
    for (int i = 0; i < 5; i++) drive_beat(pat[4-i], i == 0, i == 4, 1'b0);
    checks++;
    if (act_rv[2] !== 1'b1 || act_rem[2] !== 8'd0 || act_div[2] !== 1'b1) begin
      errors++;
      $display("FAIL div7 got rv=%0b rem=%0d div=%0b exp 1,0,1", act_rv[2], act_rem[2], act_div[2]);
    end
    idle(1);
    drive_beat(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (act_rv[2] !== 1'b1 || act_rem[2] !== 8'd1 || act_div[2] !== 1'b0 || act_cnt[2] !== 16'd1) begin
      errors++;
      $display("FAIL single_bit got rv=%0b rem=%0d div=%0b cnt=%0d exp 1,1,0,1",
               act_rv[2], act_rem[2], act_div[2], act_cnt[2]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_rem[k] !== exp_rem[k] || act_div[k] !== exp_div[k]) begin
        errors++;
        $display("FAIL single_rem N=%0d got %0d/%0b exp %0d/%0b", ns[k], act_rem[k], act_div[k], exp_rem[k], exp_div[k]);
      end
    end
    idle(1);
  endtask

  task automatic test_abort();
    drive_beat(1'b1, 1'b1, 1'b0, 1'b0);
    drive_beat(1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(1'b1, 1'b0, 1'b0, 1'b0);
    drive_beat(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_ab[0] !== 1'b1 || act_rv[0] !== 1'b0 || act_run[0] !== 8'd1 || act_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL abort_pulse got ab=%0b rv=%0b run=%0d cnt=%0d exp 1,0,1,1",
               act_ab[0], act_rv[0], act_run[0], act_cnt[0]);
    end
    drive_beat(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act_ab[0] !== 1'b0 || act_rv[0] !== 1'b1 || act_rem[0] !== 8'd0 || act_div[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_new got ab=%0b rv=%0b rem=%0d div=%0b exp 0,1,0,1",
               act_ab[0], act_rv[0], act_rem[0], act_div[0]);
    end
    idle(1);
  endtask

  task automatic test_orphan_reset();
    drive_beat(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_or[k] !== 1'b1 || act_rem[k] !== exp_rem[k] || act_div[k] !== exp_div[k] || act_rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL orphan N=%0d got or=%0b rem=%0d div=%0b rv=%0b exp 1,%0d,%0b,0",
                 ns[k], act_or[k], act_rem[k], act_div[k], act_rv[k], exp_rem[k], exp_div[k]);
      end
    end
    idle(1);
    checks++;
    if (act_or[0] !== 1'b0) begin
      errors++;
      $display("FAIL orphan_drop got %0b exp 0", act_or[0]);
    end
    drive_beat(1'b1, 1'b1, 1'b0, 1'b0);
    drive_beat(1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_run[k] !== 8'd0 || act_rem[k] !== 8'd0 || act_cnt[k] !== 16'd0 ||
          act_div[k] !== 1'b1 || act_rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset N=%0d got run=%0d rem=%0d cnt=%0d div=%0b rv=%0b exp 0,0,0,1,0",
                 ns[k], act_run[k], act_rem[k], act_cnt[k], act_div[k], act_rv[k]);
      end
    end
    mdl_reset();
    #2;
    rst = 1'b0;
    idle(2);
    checks++;
    if (act_rv[0] !== 1'b0 || act_run[0] !== 8'd0) begin
      errors++;
      $display("FAIL post_reset got rv=%0b run=%0d exp 0,0", act_rv[0], act_run[0]);
    end
  endtask

  task automatic test_random_frames();
    logic [39:0] w;
    logic        b, lz;
    exp_q.delete();
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < 64; i++) begin
        b  = 1'($urandom_range(0, 1));
        lz = (i == 0) ? 1'(f % 2) : 1'($urandom_range(0, 1));
        drive_beat(b, i == 0, i == 63, lz);
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (act_run[k] !== exp_run[k] || act_rv[k] !== exp_rv || act_ab[k] !== exp_ab ||
              act_or[k] !== exp_or || act_cnt[k] !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL rand_beat f=%0d i=%0d N=%0d got run=%0d rv=%0b ab=%0b or=%0b cnt=%0d exp %0d,%0b,%0b,%0b,%0d",
                     f, i, ns[k], act_run[k], act_rv[k], act_ab[k], act_or[k], act_cnt[k],
                     exp_run[k], exp_rv, exp_ab, exp_or, exp_cnt);
          end
        end
        if (i == 63) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_queue f=%0d got empty exp one entry", f);
          end else begin
            w = exp_q.pop_front();
            for (int k = 0; k < 5; k++) begin
              checks++;
              if (act_rem[k] !== w[8*k +: 8] || act_div[k] !== (w[8*k +: 8] == 8'd0)) begin
                errors++;
                $display("FAIL rand_rem f=%0d N=%0d got %0d/%0b exp %0d/%0b",
                         f, ns[k], act_rem[k], act_div[k], w[8*k +: 8], (w[8*k +: 8] == 8'd0));
              end
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          idle($urandom_range(1, 2));
        end
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_msb_mod3();
    test_lsb_bubbles();
    test_div7_single();
    test_abort();
    test_orphan_reset();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_mod_n
